// File: rtl/sseg_mux_display.sv
// Time-multiplexed hex seven-segment driver with anti-ghost blanking,
// leading-zero suppression, per-digit decimal points and frame-synchronous updates.
module sseg_mux_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  enable,
    input  logic                  lz_blank,
    output logic [7:0]            sseg_indicator,
    output logic [DIGITS-1:0]     digits,
    output logic                  frame_done
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NIB_W = 4 * DIGITS;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0]  BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  index;
    logic [NIB_W-1:0]  shadow;
    logic [NIB_W-1:0]  active;
    logic [DIGITS-1:0] dp_shadow;
    logic [DIGITS-1:0] dp_active;

    logic              slot_end_c;
    logic              frame_end_c;
    logic [3:0]        nib_c;
    logic              dp_c;
    logic              blank_c;
    logic              upper_zero_c;
    logic              lit_c;
    logic [7:0]        seg_on_c;
    logic [DIGITS-1:0] dig_on_c;
    logic [7:0]        sseg_next_c;
    logic [DIGITS-1:0] digits_next_c;

    // Active-high glyph, bit0=a .. bit6=g
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign slot_end_c  = (prescaler == PRE_LAST);
    assign frame_end_c = slot_end_c && (index == IDX_LAST);

    // Select the current digit's nibble/dp and decide leading-zero suppression,
    // scanning from the most significant digit down.
    always_comb begin
        nib_c        = 4'h0;
        dp_c         = 1'b0;
        blank_c      = 1'b0;
        upper_zero_c = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero_c = upper_zero_c & (active[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == index) begin
                nib_c   = active[4*k +: 4];
                dp_c    = dp_active[k];
                blank_c = lz_blank && (k != 0) && upper_zero_c;
            end
        end
    end

    always_comb begin
        lit_c         = enable && (prescaler >= BLANK_END);
        seg_on_c      = {dp_c, blank_c ? 7'h00 : hex_glyph(nib_c)};
        dig_on_c      = DIGITS'(1) << index;
        sseg_next_c   = SEG_OFF;
        digits_next_c = DIG_OFF;
        if (lit_c) begin
            sseg_next_c   = SEG_ACTIVE_LOW ? ~seg_on_c : seg_on_c;
            digits_next_c = DIG_ACTIVE_LOW ? ~dig_on_c : dig_on_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler      <= '0;
            index          <= '0;
            shadow         <= '0;
            active         <= '0;
            dp_shadow      <= '0;
            dp_active      <= '0;
            frame_done     <= 1'b0;
            sseg_indicator <= SEG_OFF;
            digits         <= DIG_OFF;
        end else begin
            prescaler <= slot_end_c ? '0 : prescaler + PRE_W'(1);
            if (slot_end_c) begin
                index <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
            end
            // Frame boundary takes the pre-edge shadow; a coincident load lands next frame
            if (frame_end_c) begin
                active    <= shadow;
                dp_active <= dp_shadow;
            end
            if (load) begin
                shadow    <= NIB_W'(value);
                dp_shadow <= dp_mask;
            end
            frame_done     <= frame_end_c;
            sseg_indicator <= sseg_next_c;
            digits         <= digits_next_c;
        end
    end

endmodule
